// File: rtl/esc_rx_pkg.sv
// Shared types and command constants for the escape-mode receive path.
package esc_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StLpdt,
        StUlps,
        StWait
    } esc_state_e;

    // Entry command values as assembled with the first received bit in bit 0.
    localparam logic [7:0] CMD_LPDT     = 8'h87;
    localparam logic [7:0] CMD_ULPS     = 8'h78;
    localparam logic [7:0] CMD_RST_TRIG = 8'h46;
    localparam logic [7:0] CMD_TRIG3    = 8'hBA;
    localparam logic [7:0] CMD_TRIG4    = 8'h84;
    localparam logic [7:0] CMD_TRIG5    = 8'h05;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/esc_rx_fifo.sv
// First-word-fall-through payload FIFO clocked on the falling escape-clock edge.
module esc_rx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned AddrW     = $clog2(FIFO_DEPTH),
    localparam int unsigned LvlW      = AddrW + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              valid_o,
    output logic              drop_o,
    output logic [LvlW-1:0]   level_o
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic              full, do_push, do_pop;

    assign valid_o = (level_q != '0);
    assign full    = (level_q == LvlW'(FIFO_DEPTH));
    assign do_pop  = pop_i & valid_o;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & full & ~do_pop;
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(negedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/esc_rx_deser_fifo.sv
// Escape-mode receive deserializer: entry-command decode, LPDT word assembly
// and a buffered valid/ready payload output.
module esc_rx_deser_fifo
    import esc_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        RxClkEsc,
    input  logic                        RstN,
    input  logic                        SerBit,
    input  logic                        EscDeserEn,
    input  logic                        RxReadyEsc,
    output logic [DATA_W-1:0]           RxEscData,
    output logic                        RxValidEsc,
    output logic                        RxLpdtEsc,
    output logic                        RxUlpsEsc,
    output logic [3:0]                  RxTriggerEsc,
    output logic                        ErrEscCmd,
    output logic                        ErrSyncEsc,
    output logic                        ErrOverflow,
    output logic [$clog2(FIFO_DEPTH):0] FifoLevel
);

    localparam int unsigned CntW = $clog2(DATA_W);

    localparam logic [7:0] CmdLpdt    = LSB_FIRST ? CMD_LPDT     : bit_rev8(CMD_LPDT);
    localparam logic [7:0] CmdUlps    = LSB_FIRST ? CMD_ULPS     : bit_rev8(CMD_ULPS);
    localparam logic [7:0] CmdRstTrig = LSB_FIRST ? CMD_RST_TRIG : bit_rev8(CMD_RST_TRIG);
    localparam logic [7:0] CmdTrig3   = LSB_FIRST ? CMD_TRIG3    : bit_rev8(CMD_TRIG3);
    localparam logic [7:0] CmdTrig4   = LSB_FIRST ? CMD_TRIG4    : bit_rev8(CMD_TRIG4);
    localparam logic [7:0] CmdTrig5   = LSB_FIRST ? CMD_TRIG5    : bit_rev8(CMD_TRIG5);

    esc_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              lpdt_q, lpdt_d;
    logic              ulps_q, ulps_d;
    logic [3:0]        trig_q, trig_d;
    logic              err_cmd_q, err_cmd_d;
    logic              err_sync_q, err_sync_d;
    logic              ovf_q, ovf_d;

    logic [CntW-1:0]   slot;
    logic [DATA_W-1:0] shift_bit;
    logic              push;
    logic              fifo_drop;

    // shift_q with this edge's bit placed; the command byte uses an 8-bit frame.
    always_comb begin
        if (LSB_FIRST) begin
            slot = cnt_q;
        end else if (state_q == StLpdt) begin
            slot = CntW'(DATA_W - 1) - cnt_q;
        end else begin
            slot = CntW'(7) - cnt_q;
        end
        shift_bit       = shift_q;
        shift_bit[slot] = SerBit;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        lpdt_d     = lpdt_q;
        ulps_d     = ulps_q;
        trig_d     = '0;
        err_cmd_d  = 1'b0;
        err_sync_d = 1'b0;
        ovf_d      = ovf_q | fifo_drop;
        push       = 1'b0;

        if (state_q != StIdle && !EscDeserEn) begin
            state_d    = StIdle;
            lpdt_d     = 1'b0;
            ulps_d     = 1'b0;
            err_sync_d = (cnt_q != '0) && (state_q == StCmd || state_q == StLpdt);
            cnt_d      = '0;
            shift_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (EscDeserEn) begin
                        state_d = StCmd;
                        cnt_d   = CntW'(1);
                        shift_d = shift_bit;
                        ovf_d   = 1'b0;
                    end
                end
                StCmd: begin
                    if (cnt_q == CntW'(7)) begin
                        cnt_d   = '0;
                        shift_d = '0;
                        state_d = StWait;
                        case (shift_bit[7:0])
                            CmdLpdt: begin
                                state_d = StLpdt;
                                lpdt_d  = 1'b1;
                            end
                            CmdUlps: begin
                                state_d = StUlps;
                                ulps_d  = 1'b1;
                            end
                            CmdRstTrig: trig_d    = 4'b0001;
                            CmdTrig3:   trig_d    = 4'b0010;
                            CmdTrig4:   trig_d    = 4'b0100;
                            CmdTrig5:   trig_d    = 4'b1000;
                            default:    err_cmd_d = 1'b1;
                        endcase
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = shift_bit;
                    end
                end
                StLpdt: begin
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        push    = 1'b1;
                        cnt_d   = '0;
                        shift_d = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = shift_bit;
                    end
                end
                StUlps, StWait: begin
                    state_d = state_q;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(negedge RxClkEsc or negedge RstN) begin
        if (!RstN) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            lpdt_q     <= 1'b0;
            ulps_q     <= 1'b0;
            trig_q     <= '0;
            err_cmd_q  <= 1'b0;
            err_sync_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            lpdt_q     <= lpdt_d;
            ulps_q     <= ulps_d;
            trig_q     <= trig_d;
            err_cmd_q  <= err_cmd_d;
            err_sync_q <= err_sync_d;
            ovf_q      <= ovf_d;
        end
    end

    esc_rx_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (RxClkEsc),
        .rst_ni (RstN),
        .push_i (push),
        .wdata_i(shift_bit),
        .pop_i  (RxReadyEsc),
        .rdata_o(RxEscData),
        .valid_o(RxValidEsc),
        .drop_o (fifo_drop),
        .level_o(FifoLevel)
    );

    assign RxLpdtEsc    = lpdt_q;
    assign RxUlpsEsc    = ulps_q;
    assign RxTriggerEsc = trig_q;
    assign ErrEscCmd    = err_cmd_q;
    assign ErrSyncEsc   = err_sync_q;
    assign ErrOverflow  = ovf_q;

endmodule

// File: tb/tb_esc_rx_deser_fifo.sv
// Directed bench for esc_rx_deser_fifo: an 8-bit LSB-first instance with a payload
// scoreboard, plus a 16-bit MSB-first instance for width and bit-order cases.
module tb_esc_rx_deser_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       ser8, en8, rdy8;
    logic [7:0] data8;
    logic       valid8, lpdt8, ulps8, errcmd8, errsync8, ovf8;
    logic [3:0] trig8;
    logic [2:0] level8;

    logic        ser16, en16, rdy16;
    logic [15:0] data16;
    logic        valid16, lpdt16, ulps16, errcmd16, errsync16, ovf16;
    logic [3:0]  trig16;
    logic [2:0]  level16;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [7:0] sb_q [$];

    esc_rx_deser_fifo #(.DATA_W(8), .LSB_FIRST(1'b1), .FIFO_DEPTH(4)) dut8 (
        .RxClkEsc(clk), .RstN(rst_n), .SerBit(ser8), .EscDeserEn(en8), .RxReadyEsc(rdy8),
        .RxEscData(data8), .RxValidEsc(valid8), .RxLpdtEsc(lpdt8), .RxUlpsEsc(ulps8),
        .RxTriggerEsc(trig8), .ErrEscCmd(errcmd8), .ErrSyncEsc(errsync8),
        .ErrOverflow(ovf8), .FifoLevel(level8)
    );

    esc_rx_deser_fifo #(.DATA_W(16), .LSB_FIRST(1'b0), .FIFO_DEPTH(4)) dut16 (
        .RxClkEsc(clk), .RstN(rst_n), .SerBit(ser16), .EscDeserEn(en16), .RxReadyEsc(rdy16),
        .RxEscData(data16), .RxValidEsc(valid16), .RxLpdtEsc(lpdt16), .RxUlpsEsc(ulps16),
        .RxTriggerEsc(trig16), .ErrEscCmd(errcmd16), .ErrSyncEsc(errsync16),
        .ErrOverflow(ovf16), .FifoLevel(level16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the rising edge; the DUT acts on the following falling edge.
    task automatic drive(input int sel, input logic b, input logic e);
        @(posedge clk);
        if (sel == 8) begin
            ser8 = b;
            en8  = e;
        end else begin
            ser16 = b;
            en16  = e;
        end
    endtask

    task automatic send(input int sel, input logic [31:0] val, input int nbits, input bit lsb);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, lsb ? val[i] : val[nbits-1-i], 1'b1);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // A word leaves on the falling edge when valid and ready are both high there.
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1 && valid8 === 1'b1 && rdy8 === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_underrun", sb_q.size(), 1);
            end else begin
                chk("sb_data", data8, sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int ulps_lo;
        int quiet;

        rst_n = 1'b0;
        ser8 = 1'b0; en8 = 1'b0; rdy8 = 1'b1;
        ser16 = 1'b0; en16 = 1'b0; rdy16 = 1'b0;
        #12;
        chk("rst_lpdt", lpdt8, 0);
        chk("rst_ulps", ulps8, 0);
        chk("rst_trig", trig8, 0);
        chk("rst_errs", {errcmd8, errsync8, ovf8}, 0);
        chk("rst_valid", valid8, 0);
        chk("rst_data", data8, 0);
        chk("rst_level", level8, 0);
        chk("rst_level16", level16, 0);
        @(posedge clk);
        rst_n = 1'b1;
        drive(8, 1'b0, 1'b0);
        drive(8, 1'b0, 1'b0);

        // LPDT with two payload bytes, consumer always ready
        sb_q.push_back(8'hA5);
        sb_q.push_back(8'h3C);
        send(8, 32'h87, 8, 1'b1);
        settle();
        chk("t1_lpdt", lpdt8, 1);
        chk("t1_no_valid", valid8, 0);
        send(8, 32'hA5, 8, 1'b1);
        settle();
        chk("t1_valid_lat", valid8, 1);
        chk("t1_head", data8, 8'hA5);
        send(8, 32'h3C, 8, 1'b1);
        drive(8, 1'b0, 1'b0);
        settle();
        chk("t1_exit_lpdt", lpdt8, 0);
        chk("t1_no_err", {errcmd8, errsync8, ovf8}, 0);
        drive(8, 1'b0, 1'b0);
        settle();
        chk("t1_sb_empty", sb_q.size(), 0);
        chk("t1_drained", valid8, 0);

        // ULPS held for 20 cycles, then exit
        send(8, 32'h78, 8, 1'b1);
        settle();
        chk("t2_ulps", ulps8, 1);
        ulps_lo = 0;
        for (int i = 0; i < 20; i++) begin
            drive(8, 1'($urandom_range(0, 1)), 1'b1);
            #2;
            if (ulps8 !== 1'b1 || lpdt8 !== 1'b0 || valid8 !== 1'b0) ulps_lo++;
        end
        chk("t2_ulps_hold", ulps_lo, 0);
        drive(8, 1'b0, 1'b0);
        settle();
        chk("t2_ulps_exit", ulps8, 0);
        chk("t2_no_sync", errsync8, 0);

        // Trigger 3, then an unrecognised command
        drive(8, 1'b0, 1'b0);
        send(8, 32'hBA, 8, 1'b1);
        settle();
        chk("t3_trig", trig8, 4'b0010);
        chk("t3_no_cmderr", errcmd8, 0);
        drive(8, 1'b0, 1'b1);
        settle();
        chk("t3_trig_pulse", trig8, 0);
        drive(8, 1'b0, 1'b0);
        settle();
        send(8, 32'hFF, 8, 1'b1);
        settle();
        chk("t3_cmderr", errcmd8, 1);
        chk("t3_bad_trig", trig8, 0);
        drive(8, 1'b1, 1'b1);
        settle();
        chk("t3_cmderr_pulse", errcmd8, 0);
        quiet = 0;
        for (int i = 0; i < 4; i++) begin
            drive(8, 1'b1, 1'b1);
            settle();
            if (lpdt8 | ulps8 | (|trig8) | errcmd8 | errsync8 | valid8) quiet++;
        end
        chk("t3_wait_quiet", quiet, 0);
        drive(8, 1'b0, 1'b0);
        settle();
        chk("t3_wait_exit_sync", errsync8, 0);

        // Overflow: consumer stalled, five bytes into a four-deep FIFO
        rdy8 = 1'b0;
        for (int v = 1; v <= 4; v++) sb_q.push_back(8'(v));
        send(8, 32'h87, 8, 1'b1);
        for (int v = 1; v <= 5; v++) send(8, 32'(v), 8, 1'b1);
        settle();
        chk("t4_level", level8, 4);
        chk("t4_ovf", ovf8, 1);
        chk("t4_head", data8, 8'h01);
        drive(8, 1'b0, 1'b0);
        settle();
        chk("t4_ovf_sticky", ovf8, 1);
        chk("t4_kept", level8, 4);
        drive(8, 1'b0, 1'b0);
        rdy8 = 1'b1;
        for (int i = 0; i < 6; i++) drive(8, 1'b0, 1'b0);
        settle();
        chk("t4_level_drained", level8, 0);
        chk("t4_sb_empty", sb_q.size(), 0);
        drive(8, 1'b1, 1'b1);
        settle();
        chk("t4_ovf_clear", ovf8, 0);
        drive(8, 1'b0, 1'b0);
        settle();
        chk("t4_cmd_partial_sync", errsync8, 1);
        drive(8, 1'b0, 1'b0);
        settle();
        chk("t4_sync_pulse", errsync8, 0);

        // 16-bit MSB-first: command, full word, then a 5-bit partial and exit
        send(16, 32'hE1, 8, 1'b0);
        settle();
        chk("t5_lpdt", lpdt16, 1);
        send(16, 32'h1234, 16, 1'b0);
        settle();
        chk("t5_valid", valid16, 1);
        chk("t5_word", data16, 16'h1234);
        send(16, 32'h1F, 5, 1'b0);
        drive(16, 1'b0, 1'b0);
        settle();
        chk("t5_sync", errsync16, 1);
        chk("t5_lpdt_exit", lpdt16, 0);
        chk("t5_word_kept", data16, 16'h1234);
        chk("t5_level", level16, 1);
        drive(16, 1'b0, 1'b0);
        settle();
        chk("t5_sync_pulse", errsync16, 0);
        rdy16 = 1'b1;
        drive(16, 1'b0, 1'b0);
        settle();
        chk("t5_popped", valid16, 0);

        // Asynchronous reset in the middle of an LPDT word
        rdy8 = 1'b0;
        send(8, 32'h87, 8, 1'b1);
        send(8, 32'h5A, 8, 1'b1);
        send(8, 32'h5, 3, 1'b1);
        settle();
        chk("t6_pre_level", level8, 1);
        chk("t6_pre_lpdt", lpdt8, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        en8   = 1'b0;
        #1;
        chk("t6_lpdt", lpdt8, 0);
        chk("t6_valid", valid8, 0);
        chk("t6_data", data8, 0);
        chk("t6_level", level8, 0);
        @(posedge clk);
        rst_n = 1'b1;
        rdy8  = 1'b1;
        drive(8, 1'b0, 1'b0);
        send(8, 32'h78, 8, 1'b1);
        settle();
        chk("t6_reentry_ulps", ulps8, 1);
        drive(8, 1'b0, 1'b0);
        settle();
        chk("t6_exit", ulps8, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
